// File: rtl/weight_sram_responder_pkg.sv
// Shared constants and load-FSM encoding for the weight SRAM responder.
// Imported by the CNN engine side as well as the responder itself.
package weight_sram_responder_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 10;
  localparam int WEIGHT_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    LOADED  = 2'd2
  } ld_state_t;

endpackage

// File: rtl/weight_sram_responder_mem.sv
// Single-port DEPTH x DATA_W register array with one write port
// and one registered read port that can return zero for bad addresses.
module weight_mem_array #(
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              rzero,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= rzero ? '0 : mem[raddr];
    end
  end

endmodule

// File: rtl/weight_sram_responder.sv
// Weight SRAM responder: engine read/write port plus host stream load,
// with load checksum and sticky error flags for bring-up.
module weight_sram_responder
  import weight_sram_responder_pkg::*;
#(
  parameter int DEPTH    = WEIGHT_DEPTH,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sram_en,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_we,
  input  logic [DATA_W-1:0] sram_wdata,
  output logic [DATA_W-1:0] sram_rdata,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic [DATA_W-1:0] checksum,
  output logic              ovf_err,
  output logic              addr_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  ld_state_t state, state_nx;

  logic              eng_hit;
  logic              eng_wr;
  logic              eng_rd;
  logic              ld_acc;
  logic              ld_in;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd1;

  assign eng_hit = {1'b0, sram_addr} < DEPTH_W;
  assign eng_wr  = sram_en && sram_we && eng_hit;
  assign eng_rd  = sram_en && !sram_we;
  assign ld_acc  = ld_valid && ld_ready && !rst;
  assign ld_in   = load_count < DEPTH_W;

  // Engine and load never write together: ld_ready is low under sram_en.
  assign mem_we    = eng_wr || (ld_acc && ld_in);
  assign mem_waddr = sram_en ? sram_addr[IDX_W-1:0]
                             : load_count[IDX_W-1:0];
  assign mem_wdata = sram_en ? sram_wdata : ld_data;

  weight_mem_array #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (eng_rd),
    .rzero (!eng_hit),
    .raddr (sram_addr[IDX_W-1:0]),
    .rdata (rd1)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (ld_start) state_nx = LOADING;
      end
      LOADING: begin
        if (ld_start)               state_nx = LOADING;
        else if (ld_acc && ld_last) state_nx = LOADED;
      end
      LOADED: begin
        if (ld_start) state_nx = LOADING;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ld_ready = (state == LOADING) && !sram_en && !ld_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_count <= '0;
      checksum   <= '0;
      load_done  <= 1'b0;
      ovf_err    <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      if (sram_en && !eng_hit) addr_err <= 1'b1;
      unique case (1'b1)
        ld_start: begin
          load_count <= '0;
          checksum   <= '0;
          load_done  <= 1'b0;
        end
        ld_acc: begin
          load_count <= load_count + 1'b1;
          checksum   <= checksum + ld_data;
          if (!ld_in)  ovf_err   <= 1'b1;
          if (ld_last) load_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Second stage only exists for the two-cycle latency build.
  if (READ_LAT == 2) begin : g_lat2
    logic              rd_v1;
    logic [DATA_W-1:0] rd2;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_v1 <= 1'b0;
        rd2   <= '0;
      end else begin
        rd_v1 <= eng_rd;
        if (rd_v1) rd2 <= rd1;
      end
    end

    assign sram_rdata = rd2;
  end else begin : g_lat1
    assign sram_rdata = rd1;
  end

endmodule

// File: tb/tb_weight_sram_responder.sv
// Randomized self-checking bench for weight_sram_responder
// against a behavioural memory/load model.
module tb_weight_sram_responder;

  localparam int DEPTH = 256;
  localparam int AW    = 10;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          sram_en;
  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;
  logic          ld_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          load_done;
  logic [AW:0]   load_count;
  logic [DW-1:0] checksum;
  logic          ovf_err;
  logic          addr_err;

  always #5 clk = ~clk;

  weight_sram_responder #(
    .DEPTH    (DEPTH),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .READ_LAT (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sram_en    (sram_en),
    .sram_addr  (sram_addr),
    .sram_we    (sram_we),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .checksum   (checksum),
    .ovf_err    (ovf_err),
    .addr_err   (addr_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  bit [DW-1:0] mm [DEPTH];
  bit          mk [DEPTH];
  bit          m_load;
  bit          m_done;
  int          m_cnt;
  bit [DW-1:0] m_sum;
  bit          m_ovf;
  bit          m_aerr;
  bit [DW-1:0] m_rd;
  bit          m_rdk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    int a;
    #1;
    chk("ld_ready", 64'(ld_ready), 64'(m_load && !sram_en && !ld_start));
    if (rst) begin
      m_rd   = '0;
      m_rdk  = 1'b1;
      m_load = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      m_sum  = '0;
      m_ovf  = 1'b0;
      m_aerr = 1'b0;
    end else begin
      a = int'(sram_addr);
      if (sram_en) begin
        if (a < DEPTH) begin
          if (sram_we) begin
            mm[a] = sram_wdata;
            mk[a] = 1'b1;
          end else begin
            m_rd  = mm[a];
            m_rdk = mk[a];
          end
        end else begin
          m_aerr = 1'b1;
          if (!sram_we) begin
            m_rd  = '0;
            m_rdk = 1'b1;
          end
        end
      end
      if (ld_start) begin
        m_load = 1'b1;
        m_cnt  = 0;
        m_sum  = '0;
        m_done = 1'b0;
      end else if (m_load && !sram_en && ld_valid) begin
        if (m_cnt < DEPTH) begin
          mm[m_cnt] = ld_data;
          mk[m_cnt] = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
        m_cnt++;
        m_sum = m_sum + ld_data;
        if (ld_last) begin
          m_load = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (m_rdk) chk("rdata", 64'(sram_rdata), 64'(m_rd));
    chk("load_done", 64'(load_done), 64'(m_done));
    chk("load_count", 64'(load_count), 64'(m_cnt % 2048));
    chk("checksum", 64'(checksum), 64'(m_sum));
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    chk("addr_err", 64'(addr_err), 64'(m_aerr));
    @(negedge clk);
  endtask

  task automatic drv(bit r, bit st, bit v, logic [DW-1:0] d, bit l,
                     bit en, bit we, int a, logic [DW-1:0] wd);
    rst        = r;
    ld_start   = st;
    ld_valid   = v;
    ld_data    = d;
    ld_last    = l;
    sram_en    = en;
    sram_we    = we;
    sram_addr  = AW'(a);
    sram_wdata = wd;
    step();
  endtask

  task automatic idle();
    drv(0, 0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic start();
    drv(0, 1, 0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic beat(logic [DW-1:0] d, bit l);
    drv(0, 0, 1, d, l, 0, 0, 0, '0);
  endtask

  task automatic rd(int a);
    drv(0, 0, 0, '0, 0, 1, 0, a, '0);
  endtask

  initial begin
    bit r, st, v, l, en, we;
    rst = 1'b1; ld_start = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
    sram_en = 0; sram_we = 0; sram_addr = '0; sram_wdata = '0;
    m_rdk = 1'b0;
    @(negedge clk);

    drv(1, 0, 0, '0, 0, 0, 0, 0, '0);
    drv(1, 0, 0, '0, 0, 0, 0, 0, '0);
    chk("rst_rdata", 64'(sram_rdata), 64'd0);
    chk("rst_count", 64'(load_count), 64'd0);
    idle();
    chk("idle_ready", 64'(ld_ready), 64'd0);

    start();
    beat(32'h11, 0);
    beat(32'h22, 0);
    beat(32'h33, 0);
    beat(32'h44, 1);
    chk("load4_count", 64'(load_count), 64'd4);
    chk("load4_cksum", 64'(checksum), 64'hAA);
    chk("load4_done", 64'(load_done), 64'd1);
    for (int i = 0; i < 4; i++) rd(i);
    chk("rd3", 64'(sram_rdata), 64'h44);
    idle();

    start();
    drv(0, 0, 1, 32'h55, 0, 1, 0, 1, '0);
    chk("cont_count", 64'(load_count), 64'd0);
    beat(32'h55, 0);
    beat(32'h66, 1);
    chk("cont_count2", 64'(load_count), 64'd2);
    rd(0);
    chk("cont_rd0", 64'(sram_rdata), 64'h55);

    start();
    for (int i = 0; i <= DEPTH; i++) beat(DW'(i * 3 + 7), i == DEPTH);
    chk("ovf_flag", 64'(ovf_err), 64'd1);
    chk("ovf_count", 64'(load_count), 64'(DEPTH + 1));
    rd(0); rd(3); rd(DEPTH - 1);
    chk("ovf_last_word", 64'(sram_rdata), 64'((DEPTH - 1) * 3 + 7));

    drv(0, 0, 0, '0, 0, 1, 1, 5, 32'hDEADBEEF);
    rd(5);
    chk("raw_5", 64'(sram_rdata), 64'hDEADBEEF);
    rd(300);
    chk("oob_rd", 64'(sram_rdata), 64'd0);
    chk("oob_err", 64'(addr_err), 64'd1);
    idle();

    start();
    beat(32'hA1, 0);
    beat(32'hB2, 0);
    start();
    chk("restart_cnt", 64'(load_count), 64'd0);
    chk("restart_sum", 64'(checksum), 64'd0);
    chk("restart_done", 64'(load_done), 64'd0);
    beat(32'hC3, 0);
    beat(32'hD4, 0);
    drv(1, 0, 0, '0, 0, 0, 0, 0, '0);
    idle();
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    rd(0);
    chk("keep_0", 64'(sram_rdata), 64'hC3);
    rd(1);
    chk("keep_1", 64'(sram_rdata), 64'hD4);

    for (int k = 0; k < 1500; k++) begin
      r  = ($urandom % 200) == 0;
      st = ($urandom % 40) == 0;
      v  = ($urandom % 10) < 7;
      l  = ($urandom % 20) == 0;
      en = ($urandom % 10) < 3;
      we = ($urandom % 3) == 0;
      if (r) begin
        v  = 1'b0;
        en = 1'b0;
      end
      drv(r, st, v, $urandom, l, en, we,
          int'($urandom_range(0, 299)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/weight_sram_responder.md
Name: weight_sram_responder

Overview:
Responder side of the weight-SRAM port driven by the dilated-CNN engine (sram_en/sram_addr/sram_we/sram_wdata/sram_rdata). Holds the network weight words in a register-array memory and answers engine reads with fixed latency. It also accepts a host-side streaming load (valid/ready) that fills the memory from address 0 before inference. Keeps a load checksum and sticky error flags for bring-up.

Parameters:
DEPTH, 256, number of 32-bit words stored (addresses 0..DEPTH-1)
ADDR_W, 10, engine address width (must satisfy 2**ADDR_W >= DEPTH)
DATA_W, 32, word width
READ_LAT, 1, engine read latency in cycles (legal values 1 or 2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
sram_en  in  1  engine access strobe
sram_addr  in  ADDR_W  engine word address
sram_we  in  1  engine write (valid only with sram_en)
sram_wdata  in  DATA_W  engine write data
sram_rdata  out  DATA_W  engine read data, registered
ld_start  in  1  pulse: begin new load, clears pointer/checksum
ld_valid  in  1  host load beat valid
ld_data  in  DATA_W  host load word
ld_last  in  1  final beat of load
ld_ready  out  1  responder can take a load beat
load_done  out  1  load completed (ld_last accepted)
load_count  out  ADDR_W+1  beats accepted in current/last load
checksum  out  DATA_W  mod-2^32 sum of all accepted load words
ovf_err  out  1  sticky: load beat beyond DEPTH (dropped)
addr_err  out  1  sticky: engine access with sram_addr >= DEPTH

Behaviour:
- Reset (rst=1 at clk edge): sram_rdata=0, ld_ready=0, load_done=0, load_count=0, checksum=0, ovf_err=0, addr_err=0, FSM=IDLE, read pipeline cleared. Memory contents not reset. Reset during LOADING aborts the load; words already written stay.
- FSM states IDLE, LOADING, LOADED.
  - IDLE -> LOADING on ld_start. LOADED -> LOADING on ld_start. ld_start in LOADING restarts (pointer=0, count=0, checksum=0, load_done=0); no beat is accepted in the ld_start cycle.
  - LOADING -> LOADED when a beat with ld_last is accepted; load_done=1 next cycle, held until next ld_start or rst.
- ld_ready = (FSM==LOADING) && !sram_en && !ld_start. Combinational from sram_en; the engine has no stall, so it always wins the memory.
- Accepted beat (ld_valid && ld_ready): if pointer < DEPTH, mem[pointer] <= ld_data; else word dropped, ovf_err<=1. pointer, load_count increment; checksum += ld_data (wraps mod 2^32) even for dropped words.
- Engine write (sram_en && sram_we): addr < DEPTH -> mem[addr] <= sram_wdata; else dropped, addr_err<=1. sram_rdata unchanged.
- Engine read (sram_en && !sram_we): word captured in the edge-N cycle appears on sram_rdata after READ_LAT edges (READ_LAT=1: valid the cycle after sram_en). addr >= DEPTH returns 0 and sets addr_err. Back-to-back reads every cycle are supported at full rate.
- Read-after-write same address on the next cycle returns the new data (no bypass needed; the write completes at the edge).
- sram_rdata holds its last value when no read is in flight.
- Engine reads are served in every FSM state; content before load_done is whatever the memory holds.

Decomposition:
- Shared package: DATA_W and ADDR_W defaults, FSM state encoding (IDLE=2'd0, LOADING=2'd1, LOADED=2'd2), WEIGHT_DEPTH constant shared with the CNN engine.
- One sub-module natural: weight_mem_array (single-port DEPTH x DATA_W register array, one write port, one registered read port); the top-level arbitration/FSM/checksum logic sits around it.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0, ld_ready=0 in IDLE.
- Load 4 words 0x11,0x22,0x33,0x44 (last on 4th) -> load_count=4, checksum=0xAA, load_done=1; engine reads addr 0..3 back-to-back -> rdata 0x11,0x22,0x33,0x44 one cycle after each sram_en.
- Contention: sram_en=1 during LOADING with ld_valid=1 -> ld_ready=0 that cycle, beat held and accepted the following cycle; no data loss, count correct.
- Overflow: DEPTH=4, load 6 beats -> ovf_err=1, mem[0..3] = first 4 words, load_count=6, checksum includes all 6.
- Engine write 0xDEADBEEF to addr 5, read addr 5 next cycle -> rdata 0xDEADBEEF; read addr 300 (DEPTH=256) -> rdata 0, addr_err=1.
- Restart and reset: ld_start mid-load after 2 beats -> count/checksum cleared, load_done=0; rst mid-load -> FSM IDLE, ld_ready=0, earlier written words still readable.
